// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / SRAM stall controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int REG_ADDR_W      = 4;
  localparam int WAIT_CNT_W      = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// RAW hazard compare of the ID-stage sources against the EX and MEM destinations.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_r_en,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  hazard
);

  logic ex_match;
  logic mem_match;

  always_comb begin
    ex_match  = ex_wb_en & ((ex_dest == id_src1) | (id_two_src & (ex_dest == id_src2)));
    mem_match = mem_wb_en & ((mem_dest == id_src1) | (id_two_src & (mem_dest == id_src2)));
    // With forwarding only a load in EX cannot be bypassed in time.
    if (FWD_EN != 0) hazard = ex_match & ex_mem_r_en;
    else             hazard = ex_match | mem_match;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline freeze/bubble/flush control with an SRAM wait FSM, timeout abort
// and a saturating stall-cycle counter.
//   state | meaning
//   IDLE  | no access outstanding; a memory request stalls and starts one
//   WAIT  | access in flight; stall until sram_ready or timeout
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN  = 1,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_r_en,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_branch,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic                  sram_ready,
  output logic                  freeze_if,
  output logic                  freeze_pipe,
  output logic                  bubble_id,
  output logic                  flush,
  output logic                  sram_start,
  output logic                  sram_err,
  output logic [15:0]           stall_count
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  state_t                  state;
  state_t                  state_next;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    mem_req;
  logic                    mem_stall;
  logic                    timeout_hit;
  logic                    hazard;

  hazard_detect #(.FWD_EN(FWD_EN)) u_hazard_detect (
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .ex_wb_en    (ex_wb_en),
    .ex_mem_r_en (ex_mem_r_en),
    .ex_dest     (ex_dest),
    .mem_wb_en   (mem_wb_en),
    .mem_dest    (mem_dest),
    .hazard      (hazard)
  );

  assign mem_req     = mem_r_en | mem_w_en;
  // A ready arriving on the last count is a normal completion, not a timeout.
  assign timeout_hit = (state == WAIT) & ~sram_ready & (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mem_req) state_next = WAIT;
      WAIT: if (sram_ready | timeout_hit) state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE: mem_stall = mem_req;
      WAIT: mem_stall = ~sram_ready & ~timeout_hit;
    endcase
  end

  assign freeze_pipe = mem_stall;
  assign flush       = ex_branch & ~mem_stall;
  assign freeze_if   = mem_stall | (hazard & ~flush);
  assign bubble_id   = (hazard | flush) & ~mem_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      sram_start  <= 1'b0;
      sram_err    <= 1'b0;
      stall_count <= '0;
    end else begin
      wait_cnt   <= (state == IDLE) ? '0 : wait_cnt + 1'b1;
      sram_start <= (state == IDLE) & mem_req;
      sram_err   <= sram_err | timeout_hit;
      if (freeze_if && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_src1, id_src2, ex_dest, mem_dest;
  logic        id_two_src, ex_wb_en, ex_mem_r_en, ex_branch;
  logic        mem_wb_en, mem_r_en, mem_w_en, sram_ready;

  logic        freeze_if, freeze_pipe, bubble_id, flush, sram_start, sram_err;
  logic [15:0] stall_count;
  logic        freeze_if0, freeze_pipe0, bubble_id0, flush0, sram_start0, sram_err0;
  logic [15:0] stall_count0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FWD_EN(1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_dest(ex_dest), .ex_branch(ex_branch),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .sram_ready(sram_ready), .freeze_if(freeze_if), .freeze_pipe(freeze_pipe),
    .bubble_id(bubble_id), .flush(flush), .sram_start(sram_start), .sram_err(sram_err),
    .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.FWD_EN(0), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_dest(ex_dest), .ex_branch(ex_branch),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .sram_ready(sram_ready), .freeze_if(freeze_if0), .freeze_pipe(freeze_pipe0),
    .bubble_id(bubble_id0), .flush(flush0), .sram_start(sram_start0), .sram_err(sram_err0),
    .stall_count(stall_count0)
  );

  typedef struct packed {
    logic        chk0;
    logic        fi0;
    logic        fi;
    logic        fp;
    logic        bub;
    logic        fl;
    logic        ss;
    logic        err;
    logic [15:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_sc  = 16'd0;
  exp_t        mon_e;
  string       mon_nm;

  task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", nm, fld, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      cmp(mon_nm, "freeze_if",   {15'd0, freeze_if},   {15'd0, mon_e.fi});
      cmp(mon_nm, "freeze_pipe", {15'd0, freeze_pipe}, {15'd0, mon_e.fp});
      cmp(mon_nm, "bubble_id",   {15'd0, bubble_id},   {15'd0, mon_e.bub});
      cmp(mon_nm, "flush",       {15'd0, flush},       {15'd0, mon_e.fl});
      cmp(mon_nm, "sram_start",  {15'd0, sram_start},  {15'd0, mon_e.ss});
      cmp(mon_nm, "sram_err",    {15'd0, sram_err},    {15'd0, mon_e.err});
      cmp(mon_nm, "stall_count", stall_count,          mon_e.sc);
      if (mon_e.chk0) cmp(mon_nm, "freeze_if_nofwd", {15'd0, freeze_if0}, {15'd0, mon_e.fi0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {id_src1, id_src2, ex_dest, mem_dest} = '0;
    {id_two_src, ex_wb_en, ex_mem_r_en, ex_branch} = '0;
    {mem_wb_en, mem_r_en, mem_w_en, sram_ready} = '0;
  endtask

  task automatic load_use(input logic [3:0] r);
    ex_wb_en = 1'b1; ex_mem_r_en = 1'b1; ex_dest = r; id_src1 = r;
  endtask

  // Queues the expectation for the current cycle; stall model tracks expected freeze_if.
  task automatic step(input string nm, input bit chk, input bit fi, fp, bub, fl, ss, err,
                      input int fi0 = -1);
    exp_t e;
    if (!rst) exp_sc = 16'd0;
    e.chk0 = (fi0 >= 0);
    e.fi0  = (fi0 == 1);
    e.fi = fi; e.fp = fp; e.bub = bub; e.fl = fl; e.ss = ss; e.err = err;
    e.sc = exp_sc;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    if (rst && fi && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clear_in();

    // reset state and combinational decode while held in reset
    tick(); step("reset_idle", 1, 0,0,0,0,0,0, 0);
    tick(); load_use(4'd3);
    step("reset_comb", 1, 1,0,1,0,0,0, 1);

    // load-use with forwarding
    tick(); rst = 1'b1;
    step("load_use", 1, 1,0,1,0,0,0, 1);
    tick(); clear_in();
    step("after_load_use", 1, 0,0,0,0,0,0, 0);
    tick(); ex_wb_en = 1; ex_dest = 4'd3; id_src1 = 4'd3;
    step("alu_raw_fwd", 1, 0,0,0,0,0,0, 1);

    // MEM-stage RAW only matters without forwarding
    tick(); clear_in(); mem_wb_en = 1; mem_dest = 4'd5; id_two_src = 1; id_src2 = 4'd5;
    step("mem_raw_src2", 1, 0,0,0,0,0,0, 1);
    tick(); id_two_src = 0;
    step("mem_raw_one_src", 1, 0,0,0,0,0,0, 0);

    tick(); clear_in(); ex_wb_en = 1; ex_mem_r_en = 1; ex_dest = 4'd7;
    id_src1 = 4'd1; id_src2 = 4'd7; id_two_src = 1;
    step("load_use_src2", 1, 1,0,1,0,0,0, 1);
    tick(); id_two_src = 0;
    step("src2_not_real", 1, 0,0,0,0,0,0, 0);

    tick(); clear_in(); load_use(4'd3); ex_branch = 1;
    step("branch_wins", 1, 0,0,1,1,0,0, 0);
    tick(); clear_in();
    step("quiet", 1, 0,0,0,0,0,0);

    // SRAM read, ready three cycles later
    tick(); mem_r_en = 1;
    step("rd_c1", 1, 1,1,0,0,0,0);
    tick(); step("rd_c2", 1, 1,1,0,0,1,0);
    tick(); step("rd_c3", 1, 1,1,0,0,0,0);
    tick(); sram_ready = 1;
    step("rd_c4_release", 1, 0,0,0,0,0,0);

    // back-to-back write, with a branch held across the stall
    tick(); sram_ready = 0; mem_r_en = 0; mem_w_en = 1;
    step("b2b_detect", 1, 1,1,0,0,0,0);
    tick(); ex_branch = 1;
    step("branch_in_wait1", 1, 1,1,0,0,1,0);
    tick(); step("branch_in_wait2", 1, 1,1,0,0,0,0);
    tick(); sram_ready = 1;
    step("branch_released", 1, 0,0,1,1,0,0);
    tick(); clear_in();
    step("post_branch", 1, 0,0,0,0,0,0);

    // timeout: 16 stall cycles, then release with a sticky error
    tick(); mem_w_en = 1;
    step("to_start", 1, 1,1,0,0,0,0);
    for (int i = 0; i < 15; i++) begin
      tick(); step("to_wait", 1, 1,1,0,0, (i == 0), 0);
    end
    tick(); step("to_release", 1, 0,0,0,0,0,0);
    tick(); mem_w_en = 0;
    step("to_err", 1, 0,0,0,0,0,1);
    tick(); step("err_sticky", 1, 0,0,0,0,0,1);

    // asynchronous reset in the middle of a wait
    tick(); mem_r_en = 1;
    step("rst_req", 1, 1,1,0,0,0,1);
    tick(); step("rst_wait", 1, 1,1,0,0,1,1);
    tick(); rst = 0; mem_r_en = 0;
    step("rst_async", 1, 0,0,0,0,0,0);
    tick(); rst = 1;
    step("rst_idle", 1, 0,0,0,0,0,0);

    // saturation of the stall counter
    tick(); load_use(4'd9);
    for (int i = 0; i < 70000; i++) begin
      if (i != 0) tick();
      step("sat", (i == 0 || i == 65534 || i == 65535 || i == 65536 || i == 69999),
           1,0,1,0,0,0);
    end
    tick(); clear_in();
    step("sat_end", 1, 0,0,0,0,0,0);

    tick();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
